instruction_mem_loader: RTL and testbench
=========================================

Name: instruction_mem_loader

Overview:
- Write-side counterpart to the instruction memory read port.
- Accepts a byte stream (valid/ready), parses a 2-byte word-count header, and assembles little-endian 32-bit instructions.
- Issues one single-cycle write per word to the instruction memory write port at consecutive word addresses from BASE_ADDR.
- Used as the boot/program loader ahead of processor reset release.

Parameters:
BASE_ADDR, 32'h0, byte address of the first word written (must be 4-aligned).
MAX_WORDS, 1024, largest accepted word count; header values above this are rejected.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse begins a load; ignored while busy=1
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts byte_data this cycle; a transfer occurs when byte_valid and byte_ready are both 1
mem_we  output  1  instruction memory write enable, one-cycle pulse per word
mem_addr  output  32  byte address of the write, valid when mem_we=1
mem_wdata  output  32  instruction word, valid when mem_we=1
busy  output  1  load in progress
done  output  1  one-cycle pulse on successful completion
error  output  1  sticky; set on header overflow, cleared by next accepted start
words_written  output  16  count of words written in the current/last load
checksum  output  32  XOR of all words written in the current/last load

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE.
  - byte_ready, mem_we, busy, done, error = 0.
  - mem_addr, mem_wdata, words_written, checksum = 0.
  - Internal count and byte index = 0.
- States are IDLE, HDR0, HDR1, DATA, WRITE, FINISH.
- IDLE: byte_ready=0.
  - On start=1: go to HDR0; busy=1; clear error, words_written, checksum.
- HDR0: byte_ready=1.
  - On transfer: latch count[7:0]; go to HDR1.
- HDR1: byte_ready=1. On transfer, latch count[15:8], then:
  - Count=0: go to FINISH.
  - Count>MAX_WORDS: set error; busy=0; go to IDLE; no done pulse.
  - Otherwise: go to DATA with byte index=0.
- DATA: byte_ready=1.
  - Each transfer places byte_data into bits [8*idx+7:8*idx] of the word buffer; idx increments.
  - On the transfer with idx=3: go to WRITE.
- WRITE: lasts exactly one cycle.
  - byte_ready=0, mem_we=1.
  - mem_addr = BASE_ADDR + 4*words_written (pre-increment value).
  - mem_wdata = the assembled word.
  - At the end of the cycle: words_written increments and checksum ^= word.
  - If the new words_written equals count, go to FINISH; otherwise go to DATA with idx=0.
- FINISH: done=1 for one cycle; busy=0 from the next cycle; return to IDLE.
- Latency: the write occurs on the cycle after the 4th byte of a word is accepted. Peak throughput is 4 bytes per 5 cycles.
- mem_we is 0 in every state except WRITE. mem_addr and mem_wdata hold their last values otherwise.
- byte_valid=0 stalls the FSM in place. No timeout.
- start while busy=1 has no effect.
- Address arithmetic is 32-bit, wrap-around modulo 2^32. words_written is 16-bit and cannot overflow because MAX_WORDS ≤ 65535.
- Reset mid-load aborts immediately: no further mem_we, and a partially assembled word is discarded.

Test Plan:
1. Reset, start, then stream 02 00 13 00 00 00 93 00 10 00 -> two writes:
   - mem_we@addr 0x0 data 0x00000013.
   - mem_we@addr 0x4 data 0x00100093.
   - Then done pulse, words_written=2, checksum=0x00100080, error=0.
2. Header 00 00 -> no mem_we; done pulses exactly 2 cycles after the second header byte; words_written=0.
3. Header 01 04 (1025 > MAX_WORDS) -> error=1, busy=0, no done, no writes.
   - A following start clears error.
4. Valid-stall: deassert byte_valid for 5 cycles between bytes 2 and 3 of a word -> identical mem_wdata, with the write delayed by 5 cycles.
   - Also check byte_ready=0 during WRITE.
5. Assert reset_n=0 after 2 of 4 data bytes -> all outputs return to reset values at once.
   - After a new start, the first write lands at BASE_ADDR.
6. start pulsed during DATA -> ignored; the load completes normally with the original count.

Source files
------------

// File: rtl/instruction_mem_loader.sv
// -----------------------------------------------------------------------------
// instruction_mem_loader
//
// Boot/program loader that fills the instruction memory before the processor
// leaves reset. A load begins with a one-cycle start pulse. The loader then
// reads a byte stream: a 2-byte little-endian word count, followed by that
// many little-endian 32-bit instructions. Each completed instruction is written
// with a single-cycle mem_we pulse, at consecutive word addresses starting at
// BASE_ADDR.
//
// Handshake: byte_ready is a registered output. A byte transfers on a rising
// edge where byte_valid and byte_ready are both 1. The loader never looks at
// byte_data when that condition is false. byte_valid=0 simply holds the FSM
// where it is, and there is no timeout. The source may hold byte_valid high
// while byte_ready is 0 (for example during the WRITE cycle), and the byte is
// taken once byte_ready returns.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   start         one-cycle pulse that begins a load; ignored while busy
//   byte_valid    byte_data is valid this cycle
//   byte_data     stream byte
//   byte_ready    loader accepts byte_data this cycle
//   mem_we        one-cycle write strobe per instruction word
//   mem_addr      byte address of the write (held between writes)
//   mem_wdata     instruction word (held between writes)
//   busy          load in progress
//   done          one-cycle pulse on successful completion
//   error         sticky header-overflow flag, cleared by the next start
//   words_written words written in the current/last load
//   checksum      XOR of all words written in the current/last load
//   dbg_state     current FSM state, for debug and assertion binding
// -----------------------------------------------------------------------------
module instruction_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written,
  output logic [31:0] checksum,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR0   = 3'd1,
    S_HDR1   = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_count;
  logic [1:0]  r_idx;
  // Only the low three bytes are buffered. The fourth byte goes straight into
  // mem_wdata on the cycle it arrives.
  logic [23:0] r_word;

  logic        r_byte_ready;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_words_written;
  logic [31:0] r_checksum;

  logic        w_xfer;
  logic [15:0] w_hdr_count;
  logic        w_too_big;
  logic [15:0] w_ww_next;
  logic [31:0] w_wr_addr;

  assign w_xfer      = byte_valid & r_byte_ready;
  assign w_hdr_count = {byte_data, r_count[7:0]};
  assign w_too_big   = ({16'h0, w_hdr_count} > MAX_WORDS);
  assign w_ww_next   = r_words_written + 16'd1;
  // Address of the word now being written: BASE_ADDR + 4*words_written,
  // computed modulo 2^32.
  assign w_wr_addr   = BASE_ADDR + {14'd0, r_words_written, 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_count         <= 16'd0;
      r_idx           <= 2'd0;
      r_word          <= 24'd0;
      r_byte_ready    <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= 32'd0;
      r_mem_wdata     <= 32'd0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
      r_words_written <= 16'd0;
      r_checksum      <= 32'd0;
    end else begin
      // Both strobes are pulses. They are asserted only on the transition
      // that needs them.
      r_done   <= 1'b0;
      r_mem_we <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state         <= S_HDR0;
            r_busy          <= 1'b1;
            r_byte_ready    <= 1'b1;
            r_error         <= 1'b0;
            r_words_written <= 16'd0;
            r_checksum      <= 32'd0;
          end
        end

        S_HDR0: begin
          if (w_xfer) begin
            r_count[7:0] <= byte_data;
            r_state      <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (w_xfer) begin
            r_count <= w_hdr_count;
            if (w_hdr_count == 16'd0) begin
              r_state      <= S_FINISH;
              r_byte_ready <= 1'b0;
            end else if (w_too_big) begin
              r_state      <= S_IDLE;
              r_error      <= 1'b1;
              r_busy       <= 1'b0;
              r_byte_ready <= 1'b0;
            end else begin
              r_state <= S_DATA;
              r_idx   <= 2'd0;
            end
          end
        end

        S_DATA: begin
          if (w_xfer) begin
            if (r_idx == 2'd3) begin
              // The write outputs are registered here, so the write cycle
              // lines up with the WRITE state.
              r_mem_wdata  <= {byte_data, r_word};
              r_mem_addr   <= w_wr_addr;
              r_mem_we     <= 1'b1;
              r_byte_ready <= 1'b0;
              r_state      <= S_WRITE;
            end else begin
              case (r_idx)
                2'd0:    r_word[7:0]   <= byte_data;
                2'd1:    r_word[15:8]  <= byte_data;
                default: r_word[23:16] <= byte_data;
              endcase
              r_idx <= r_idx + 2'd1;
            end
          end
        end

        S_WRITE: begin
          r_words_written <= w_ww_next;
          r_checksum      <= r_checksum ^ r_mem_wdata;
          r_idx           <= 2'd0;
          if (w_ww_next == r_count) begin
            r_state <= S_FINISH;
          end else begin
            r_state      <= S_DATA;
            r_byte_ready <= 1'b1;
          end
        end

        S_FINISH: begin
          // done and the busy drop appear together, one cycle after FINISH.
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_byte_ready <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready    = r_byte_ready;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign words_written = r_words_written;
  assign checksum      = r_checksum;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_instruction_mem_loader.sv
module tb_instruction_mem_loader;

  localparam logic [31:0] BASE = 32'h0;
  localparam int unsigned MAXW = 1024;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;
  logic [31:0] checksum;
  logic [2:0]  dbg_state;

  instruction_mem_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_written(words_written),
    .checksum     (checksum),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];       // {addr, data} of expected writes, in order
  logic [31:0] tx_words[$];    // words of the load being driven
  int done_cnt       = 0;
  int last_we_cyc    = 0;
  int load_start_cyc = 0;
  int stall_idx      = -1;     // data byte index preceded by a forced stall
  int stall_len      = 0;
  bit poke_start     = 1'b0;   // pulse start during that stall

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Write monitor: each mem_we pulse is matched against the next expected write.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_we) begin
      last_we_cyc = cyc;
      check("byte_ready_in_write", {63'd0, byte_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=no write", mem_addr, mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr", {32'd0, mem_addr}, {32'd0, e[63:32]});
        check("write_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call just after a negedge. Returns at the negedge following the transfer.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      checks++;
      failures++;
      $display("FAIL byte_ready_timeout actual=0 required=1 after 100 cycles");
      byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    load_start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic        last_err;
  logic [15:0] last_ww;
  logic [31:0] last_csum;

  // One complete load. The expected result comes from the stream rules:
  // writes at BASE+4*i, XOR checksum, reject counts above MAXW.
  task automatic run_load(input logic [15:0] cnt, input int gap_max);
    logic        m_err;
    logic [15:0] m_ww;
    logic [31:0] m_csum;
    logic [31:0] wv;
    int          t;
    int          done_before;

    m_err  = (cnt > MAXW);
    m_ww   = 16'd0;
    m_csum = 32'd0;
    if (!m_err) begin
      for (int i = 0; i < int'(cnt); i++) begin
        exp_q.push_back({BASE + 32'(4 * i), tx_words[i]});
        m_csum ^= tx_words[i];
      end
      m_ww = cnt;
    end

    pulse_start();
    check("busy_after_start",  {63'd0, busy}, 64'd1);
    check("error_cleared",     {63'd0, error}, 64'd0);
    check("ww_cleared",        {48'd0, words_written}, 64'd0);
    check("checksum_cleared",  {32'd0, checksum}, 64'd0);
    done_before = done_cnt;

    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
    if (!m_err) begin
      for (int w = 0; w < int'(cnt); w++) begin
        wv = tx_words[w];
        for (int k = 0; k < 4; k++) begin
          if (w * 4 + k == stall_idx) begin
            for (int s = 0; s < stall_len; s++) begin
              if (poke_start && s == 0) start = 1'b1;
              @(negedge clk);
              start = 1'b0;
            end
          end else begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
          end
          send_byte(wv[8*k +: 8]);
        end
      end
    end

    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=1 required=0 after 200 cycles");
    end
    if (!m_err) check("done_with_busy_drop", {63'd0, done}, 64'd1);
    @(negedge clk);
    check("done_pulse_count", 64'(done_cnt - done_before), m_err ? 64'd0 : 64'd1);
    check("busy_end",        {63'd0, busy}, 64'd0);
    check("error_end",       {63'd0, error}, {63'd0, m_err});
    check("words_written",   {48'd0, words_written}, {48'd0, m_ww});
    check("checksum",        {32'd0, checksum}, {32'd0, m_csum});
    check("writes_drained",  64'(exp_q.size()), 64'd0);
    exp_q.delete();
    last_err  = error;
    last_ww   = words_written;
    last_csum = checksum;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        e_err;
    logic [15:0] e_ww;
    logic [31:0] e_csum;
  } vec_t;

  vec_t tbl[6];

  // ---------------- main sequence ----------------
  initial begin
    int lat0;
    int lat1;
    logic [15:0] rc;
    int r;

    reset_n    = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    tbl[0] = '{16'd2,      32'h0000_0013, 32'h0010_0093, 1'b0, 16'd2, 32'h0010_0080};
    tbl[1] = '{16'd0,      32'h0,         32'h0,         1'b0, 16'd0, 32'h0};
    tbl[2] = '{16'h0401,   32'h0,         32'h0,         1'b1, 16'd0, 32'h0};
    tbl[3] = '{16'd1,      32'hDEAD_BEEF, 32'h0,         1'b0, 16'd1, 32'hDEAD_BEEF};
    tbl[4] = '{16'd2,      32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0, 16'd2, 32'hF0F0_F0F0};
    tbl[5] = '{16'hFFFF,   32'h0,         32'h0,         1'b1, 16'd0, 32'h0};

    repeat (3) @(negedge clk);
    check("rst_byte_ready", {63'd0, byte_ready}, 64'd0);
    check("rst_busy",       {63'd0, busy}, 64'd0);
    check("rst_done",       {63'd0, done}, 64'd0);
    check("rst_error",      {63'd0, error}, 64'd0);
    check("rst_mem_we",     {63'd0, mem_we}, 64'd0);
    check("rst_mem_addr",   {32'd0, mem_addr}, 64'd0);
    check("rst_ww",         {48'd0, words_written}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven loads.
    for (int i = 0; i < 6; i++) begin
      tx_words.delete();
      tx_words.push_back(tbl[i].w0);
      tx_words.push_back(tbl[i].w1);
      run_load(tbl[i].cnt, 0);
      check("tbl_error", {63'd0, last_err}, {63'd0, tbl[i].e_err});
      check("tbl_ww",    {48'd0, last_ww}, {48'd0, tbl[i].e_ww});
      check("tbl_csum",  {32'd0, last_csum}, {32'd0, tbl[i].e_csum});
    end

    // An empty header: done comes exactly two cycles after the second header byte.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    check("zero_done_not_early", {63'd0, done}, 64'd0);
    @(negedge clk);
    check("zero_done_at_2",      {63'd0, done}, 64'd1);
    check("zero_busy_low",       {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("zero_done_one_cycle", {63'd0, done}, 64'd0);
    check("zero_ww",             {48'd0, words_written}, 64'd0);

    // A valid stall delays the write by exactly the stall length.
    tx_words.delete();
    tx_words.push_back(32'hA5C3_1E77);
    run_load(16'd1, 0);
    lat0 = last_we_cyc - load_start_cyc;
    check("latency_no_stall", 64'(lat0), 64'd7);
    stall_idx = 2;
    stall_len = 5;
    run_load(16'd1, 0);
    lat1 = last_we_cyc - load_start_cyc;
    check("latency_stall5", 64'(lat1 - lat0), 64'd5);
    stall_idx = -1;

    // A start pulse during DATA is ignored.
    tx_words.delete();
    tx_words.push_back($urandom);
    tx_words.push_back($urandom);
    stall_idx  = 5;
    stall_len  = 2;
    poke_start = 1'b1;
    run_load(16'd2, 0);
    stall_idx  = -1;
    poke_start = 1'b0;

    // Randomized loads.
    for (int n = 0; n < 25; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      rc = 16'd0;
      else if (r == 1) rc = 16'($urandom_range(1025, 65535));
      else             rc = 16'($urandom_range(1, 12));
      tx_words.delete();
      for (int i = 0; i < 12; i++) tx_words.push_back($urandom);
      run_load(rc, 3);
    end

    // Largest accepted count.
    tx_words.delete();
    for (int i = 0; i < int'(MAXW); i++) tx_words.push_back($urandom);
    run_load(16'(MAXW), 0);

    // Reset mid-load: two words written, then two bytes of a third word.
    exp_q.push_back({BASE, 32'h1111_2222});
    exp_q.push_back({BASE + 32'd4, 32'h3333_4444});
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h22); send_byte(8'h22); send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h44); send_byte(8'h44); send_byte(8'h33); send_byte(8'h33);
    send_byte(8'hAA); send_byte(8'hBB);
    check("pre_reset_writes", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_byte_ready", {63'd0, byte_ready}, 64'd0);
    check("mid_rst_mem_we",     {63'd0, mem_we}, 64'd0);
    check("mid_rst_busy",       {63'd0, busy}, 64'd0);
    check("mid_rst_done",       {63'd0, done}, 64'd0);
    check("mid_rst_error",      {63'd0, error}, 64'd0);
    check("mid_rst_mem_addr",   {32'd0, mem_addr}, 64'd0);
    check("mid_rst_mem_wdata",  {32'd0, mem_wdata}, 64'd0);
    check("mid_rst_ww",         {48'd0, words_written}, 64'd0);
    check("mid_rst_checksum",   {32'd0, checksum}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tx_words.delete();
    tx_words.push_back(32'h1234_5678);
    run_load(16'd1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=still running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
